// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the clock_div_bank clock-enable generator.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MAX_CH          = 16;
  localparam int unsigned CH_IDX_W               = 4;
  localparam int unsigned CLKDIV_DIV_W_DEFAULT   = 16;
  localparam logic [15:0] CLKDIV_DIV_DEFAULT_5MS = 16'd19999;

  // True when a configuration index addresses channel ch of the bank.
  function automatic logic ch_hit(input logic [CH_IDX_W-1:0] idx, input int unsigned ch);
    return (ch < CLKDIV_MAX_CH) && (int'(idx) == int'(ch));
  endfunction

endpackage

// File: rtl/div_channel.sv
// One programmable enable channel: period counter, live and pending divisor, square/tick registers.
// With CLKDIV_PHASE_EN defined the channel also keeps a start-phase register used on sync.
module div_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned      DIV_W       = CLKDIV_DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(CLKDIV_DIV_DEFAULT_5MS)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0] wr_phase,
`endif
  output logic             sq,
  output logic             tick,
  output logic             pend
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] pend_div_nxt;
  logic [DIV_W-1:0] start_cnt;
  logic             pend_nxt;
  logic             sq_nxt;
  logic             tick_nxt;
  logic             wrap;
  logic             apply;
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] phase;
  logic [DIV_W-1:0] phase_nxt;
`endif

  // Next-state logic: a pending divisor lands only at a period boundary, sync or while idle.
  always_comb begin
    wrap         = (cnt == div);
    apply        = 1'b0;
    div_nxt      = div;
    pend_div_nxt = pend_div;
    pend_nxt     = pend;
    cnt_nxt      = cnt;
    start_cnt    = CNT_ZERO;
    sq_nxt       = 1'b0;
    tick_nxt     = 1'b0;
`ifdef CLKDIV_PHASE_EN
    phase_nxt    = phase;
`endif

    if (en) begin
      apply = pend & (sync | wrap);
    end else begin
      apply = pend;
    end

    if (apply) begin
      div_nxt  = pend_div;
      pend_nxt = 1'b0;
    end else begin
      div_nxt  = div;
    end

    // Sync start point is judged against the divisor that will be live after the apply.
`ifdef CLKDIV_PHASE_EN
    if (phase <= div_nxt) begin
      start_cnt = phase;
    end else begin
      start_cnt = CNT_ZERO;
    end
`else
    start_cnt = CNT_ZERO;
`endif

    if (!en) begin
      cnt_nxt = CNT_ZERO;
    end else if (sync) begin
      cnt_nxt = start_cnt;
    end else if (wrap) begin
      cnt_nxt = CNT_ZERO;
    end else begin
      cnt_nxt = cnt + CNT_ONE;
    end

    if (en) begin
      sq_nxt   = (cnt <= {1'b0, div[DIV_W-1:1]});
      tick_nxt = wrap & ~sync;
    end else begin
      sq_nxt   = 1'b0;
      tick_nxt = 1'b0;
    end

    // A write issued on the apply cycle stays pending for the next boundary.
    if (wr) begin
      pend_div_nxt = wr_div;
      pend_nxt     = 1'b1;
`ifdef CLKDIV_PHASE_EN
      phase_nxt    = wr_phase;
`endif
    end else begin
      pend_div_nxt = pend_div;
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= CNT_ZERO;
      div      <= DIV_DEFAULT;
      pend_div <= CNT_ZERO;
      pend     <= 1'b0;
      sq       <= 1'b0;
      tick     <= 1'b0;
`ifdef CLKDIV_PHASE_EN
      phase    <= CNT_ZERO;
`endif
    end else begin
      cnt      <= cnt_nxt;
      div      <= div_nxt;
      pend_div <= pend_div_nxt;
      pend     <= pend_nxt;
      sq       <= sq_nxt;
      tick     <= tick_nxt;
`ifdef CLKDIV_PHASE_EN
      phase    <= phase_nxt;
`endif
    end
  end

endmodule

// File: rtl/clock_div_bank.sv
// Bank of N_CH programmable clock-enable channels: config write decode and sync fan-out.
// Optional per-channel sync start phase (cfg_phase port) when CLKDIV_PHASE_EN is defined.
module clock_div_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned      N_CH        = 4,
  parameter int unsigned      DIV_W       = CLKDIV_DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(CLKDIV_DIV_DEFAULT_5MS)
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                sync_i,
  input  logic                cfg_wr,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0]    cfg_phase,
`endif
  output logic [N_CH-1:0]     sq_o,
  output logic [N_CH-1:0]     tick_o,
  output logic [N_CH-1:0]     cfg_pend
);

  logic [N_CH-1:0] wr_sel;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Indices at or above N_CH match no channel, so such writes are dropped.
    assign wr_sel[g] = cfg_wr & ch_hit(cfg_ch, g);

    div_channel #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .en       (ch_en[g]),
      .sync     (sync_i),
      .wr       (wr_sel[g]),
      .wr_div   (cfg_div),
`ifdef CLKDIV_PHASE_EN
      .wr_phase (cfg_phase),
`endif
      .sq       (sq_o[g]),
      .tick     (tick_o[g]),
      .pend     (cfg_pend[g])
    );
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// Self-checking bench for clock_div_bank: directed tables, hand sequences and a randomized run
// against a period/position reference model. Phase tests run when CLKDIV_PHASE_EN is defined.
module tb_clock_div_bank;

  localparam int N_CH  = 4;
  localparam int DIV_W = 16;
`ifdef CLKDIV_PHASE_EN
  localparam bit PHASE_ON = 1'b1;
`else
  localparam bit PHASE_ON = 1'b0;
`endif

  logic              clk_in  = 1'b0;
  logic              reset_n = 1'b1;
  logic [N_CH-1:0]   ch_en;
  logic              sync_i;
  logic              cfg_wr;
  logic [3:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_phase;
  logic [N_CH-1:0]   sq_o;
  logic [N_CH-1:0]   tick_o;
  logic [N_CH-1:0]   cfg_pend;

  int errors = 0;
  int checks = 0;

  // Reference model: period length, position inside the period, pending period and phase.
  int              per   [N_CH];
  int              pos   [N_CH];
  int              pper  [N_CH];
  int              phs   [N_CH];
  bit              pflag [N_CH];
  logic [N_CH-1:0] exp_sq;
  logic [N_CH-1:0] exp_tick;
  logic [N_CH-1:0] exp_pend;

  typedef struct {
    logic [15:0] d;
    logic [5:0]  sq_pat;
    logic [5:0]  tick_pat;
  } vec_t;
  vec_t vecs[5];

  clock_div_bank #(
    .N_CH        (N_CH),
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (16'd19999)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .ch_en     (ch_en),
    .sync_i    (sync_i),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .sq_o      (sq_o),
    .tick_o    (tick_o),
    .cfg_pend  (cfg_pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      per[c]   = 20000;
      pos[c]   = 0;
      pper[c]  = 1;
      phs[c]   = 0;
      pflag[c] = 1'b0;
    end
    exp_sq   = '0;
    exp_tick = '0;
    exp_pend = '0;
  endtask

  task automatic model_step();
    bit last;
    bit ap;
    for (int c = 0; c < N_CH; c++) begin
      last = (pos[c] == per[c] - 1);
      if (ch_en[c]) begin
        exp_sq[c]   = (pos[c] < (per[c] + 1) / 2);
        exp_tick[c] = last && !sync_i;
      end else begin
        exp_sq[c]   = 1'b0;
        exp_tick[c] = 1'b0;
      end
      ap = pflag[c] && (!ch_en[c] || sync_i || last);
      if (ap) begin
        per[c]   = pper[c];
        pflag[c] = 1'b0;
      end
      if (!ch_en[c])      pos[c] = 0;
      else if (sync_i)    pos[c] = (PHASE_ON && phs[c] < per[c]) ? phs[c] : 0;
      else if (last)      pos[c] = 0;
      else                pos[c] = pos[c] + 1;
      if (cfg_wr && int'(cfg_ch) == c) begin
        pflag[c] = 1'b1;
        pper[c]  = int'(cfg_div) + 1;
        phs[c]   = int'(cfg_phase);
      end
      exp_pend[c] = pflag[c];
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge, strobes cleared.
  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    check("sq_o", sq_o, exp_sq);
    check("tick_o", tick_o, exp_tick);
    check("cfg_pend", cfg_pend, exp_pend);
    sync_i = 1'b0;
    cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_sq", sq_o, 0);
    check("rst_tick", tick_o, 0);
    check("rst_pend", cfg_pend, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
    sync_i  = 1'b0;
    cfg_wr  = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input int d, input int ph);
    cfg_wr    = 1'b1;
    cfg_ch    = ch[3:0];
    cfg_div   = d[15:0];
    cfg_phase = ph[15:0];
  endtask

  initial begin
    int t1;
    int t2;
    int sq_hi;
    ch_en = '0; sync_i = 1'b0; cfg_wr = 1'b0;
    cfg_ch = 4'd0; cfg_div = 16'd0; cfg_phase = 16'd0;
    vecs[0] = '{16'd0, 6'b111111, 6'b111111};
    vecs[1] = '{16'd1, 6'b010101, 6'b101010};
    vecs[2] = '{16'd2, 6'b011011, 6'b100100};
    vecs[3] = '{16'd4, 6'b100111, 6'b010000};
    vecs[4] = '{16'd5, 6'b000111, 6'b100000};
    #2;
    do_reset();

    // Default period on ch0: 20000-cycle tick, 10000 cycles of sq high.
    ch_en = 4'b0001;
    t1 = -1; t2 = -1; sq_hi = 0;
    for (int i = 1; i <= 40000; i++) begin
      cyc();
      if (i <= 20000 && sq_o[0]) sq_hi++;
      if (tick_o[0]) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    check("ch0_first_tick", t1, 20000);
    check("ch0_period", t2 - t1, 20000);
    check("ch0_sq_high", sq_hi, 10000);
    ch_en = 4'b0000;
    cyc();

    // Table of small divisors on ch1, loaded while idle then started.
    for (int v = 0; v < 5; v++) begin
      ch_en[1] = 1'b0;
      write_cfg(1, int'(vecs[v].d), 0);
      cyc();
      cyc();
      check("idle_apply_pend", cfg_pend[1], 0);
      ch_en[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
        cyc();
        check($sformatf("tbl_sq d=%0d c=%0d", vecs[v].d, i), sq_o[1], vecs[v].sq_pat[i]);
        check($sformatf("tbl_tick d=%0d c=%0d", vecs[v].d, i), tick_o[1], vecs[v].tick_pat[i]);
      end
    end

    // Mid-period rewrite on ch1: D=9 period completes, then period 3.
    ch_en[1] = 1'b0;
    write_cfg(1, 9, 0);
    cyc(); cyc();
    ch_en[1] = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    write_cfg(1, 2, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i <= 5) begin
        check("rewrite_pend", cfg_pend[1], 1);
        check("rewrite_no_tick", tick_o[1], 0);
      end else if (i == 6) begin
        check("rewrite_old_wrap_tick", tick_o[1], 1);
        check("rewrite_pend_clear", cfg_pend[1], 0);
      end else begin
        check("rewrite_new_tick", tick_o[1], (i % 3) == 0);
        check("rewrite_new_sq", sq_o[1], (i % 3) != 0);
      end
    end

    // Sync of D=4 (ch2) and D=9 (ch3) started out of phase.
    write_cfg(2, 4, 0); cyc();
    write_cfg(3, 9, 0); cyc();
    cyc();
    ch_en[2] = 1'b1;
    cyc(); cyc(); cyc();
    ch_en[3] = 1'b1;
    cyc();
    sync_i = 1'b1;
    cyc();
    check("sync_suppresses_tick", tick_o[2], 0);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      check("sync_ch2_tick", tick_o[2], (i % 5) == 0);
      check("sync_ch3_tick", tick_o[3], (i % 10) == 0);
    end

    // Reset in mid-period, then restart without a spurious tick.
    do_reset();
    cyc();
    check("post_rst_tick", tick_o, 0);
    check("post_rst_sq", sq_o[3:2], 2'b11);

    // Enable toggled mid-period on ch1 with D=2.
    ch_en[1] = 1'b0;
    write_cfg(1, 2, 0);
    cyc(); cyc();
    ch_en[1] = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    ch_en[1] = 1'b0;
    cyc();
    check("dis_sq", sq_o[1], 0);
    check("dis_tick", tick_o[1], 0);
    ch_en[1] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("reen_sq", sq_o[1], i != 3);
      check("reen_tick", tick_o[1], i == 3);
    end

    // Write to a channel index beyond the bank.
    write_cfg(7, 5, 0);
    cyc();
    check("bad_ch_pend", cfg_pend, 0);

`ifdef CLKDIV_PHASE_EN
    // Start phase 7 on D=9, then out-of-range phase 12 behaves as 0.
    ch_en[3] = 1'b0;
    write_cfg(3, 9, 7);
    cyc(); cyc();
    ch_en[3] = 1'b1;
    cyc(); cyc();
    sync_i = 1'b1;
    cyc();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("phase7_tick", tick_o[3], i == 3);
    end
    write_cfg(3, 9, 12);
    cyc();
    sync_i = 1'b1;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("phase12_tick", tick_o[3], i == 10);
    end
`endif

    // Randomized traffic against the reference model.
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N_CH; c++) ch_en[c] = ($urandom_range(0, 7) != 0);
      sync_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        write_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 11)));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
